prefix_adder_sequencer: RTL

Multi-cycle parallel-prefix (Kogge-Stone) adder controller. Accepts one operand pair over a valid/ready handshake and evaluates one prefix row per clock, reusing a single row datapath for all ROWS rows. Returns a registered sum and carry-out over a second valid/ready handshake. It replaces the fully unrolled combinational prefix network where area matters more than latency.

---
 rtl/prefix_pkg.sv | 27 ++
 rtl/prefix_row.sv | 30 +++
 rtl/prefix_adder_sequencer.sv | 117 +++++++++++
 3 files changed

// File: rtl/prefix_pkg.sv
// Shared definitions for the sequential Kogge-Stone adder.
//   state_t       : sequencer states (IDLE, PREFIX, DONE)
//   calc_rows     : number of prefix rows for a given operand width
//   row_idx_width : bit width of a row counter that can hold rows-1
//   row_distance  : lookback distance of prefix row k (2^k)
package prefix_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PREFIX = 2'd1,
    DONE   = 2'd2
  } state_t;

  function automatic int calc_rows(input int width);
    return $clog2(width);
  endfunction

  // A single-row design still needs a 1-bit counter, not a 0-bit one.
  function automatic int row_idx_width(input int rows);
    return (rows > 1) ? $clog2(rows) : 1;
  endfunction

  function automatic int row_distance(input int k);
    return 1 << k;
  endfunction

endpackage

// File: rtl/prefix_row.sv
// One Kogge-Stone prefix row, purely combinational.
//   g, p         : current group generate / propagate vectors
//   row          : row index k; lookback distance is 2^k
//   g_nxt, p_nxt : vectors after combining bit i with bit i-2^k
// Bits below the distance have no partner and pass through unchanged.
module prefix_row
  import prefix_pkg::*;
#(
  parameter int WIDTH = 7,
  parameter int RW    = 2
) (
  input  logic [WIDTH-1:0] g,
  input  logic [WIDTH-1:0] p,
  input  logic [RW-1:0]    row,
  output logic [WIDTH-1:0] g_nxt,
  output logic [WIDTH-1:0] p_nxt
);

  always_comb begin
    int               d;
    logic [WIDTH-1:0] low_mask;
    d        = row_distance(int'(row));
    // Ones on the bits that have no partner at distance d.
    low_mask = (WIDTH'(1) << d) - WIDTH'(1);
    // Shifting left fills zeros, so the low bits see no extra generate.
    g_nxt    = g | (p & (g << d));
    p_nxt    = p & ((p << d) | low_mask);
  end

endmodule

// File: rtl/prefix_adder_sequencer.sv
// Multi-cycle Kogge-Stone adder: one shared prefix row evaluated once per
// clock for ROWS clocks, wrapped in valid/ready handshakes on both sides.
//   clk, rst_n           : clock (rising edge), async active-low reset
//   in_valid / in_ready  : operand handshake for a, b, cin
//   out_valid / out_ready: result handshake for sum, cout
//   sum, cout            : registered (a + b + cin), held until accepted
//   busy                 : high while prefix rows are being evaluated
module prefix_adder_sequencer
  import prefix_pkg::*;
#(
  parameter int WIDTH = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int            ROWS     = calc_rows(WIDTH);
  localparam int            RW       = row_idx_width(ROWS);
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);

  state_t           state, state_nxt;
  logic [RW-1:0]    row_cnt;
  logic [WIDTH-1:0] g_q, p_q, h_q;
  logic             cin_q;
  logic [WIDTH-1:0] g_init, g_row, p_row, carry;
  logic [WIDTH-1:0] sum_q;
  logic             cout_q;
  logic             accept, last_row;

  assign out_valid = (state == DONE);
  assign busy      = (state == PREFIX);
  // In DONE, a new operand can only enter on the edge the result leaves.
  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign last_row  = (state == PREFIX) && (row_cnt == LAST_ROW);
  assign sum       = sum_q;
  assign cout      = cout_q;

  // Carry-in is folded into bit 0's generate so the prefix network never
  // needs a separate carry path.
  always_comb begin
    g_init    = a & b;
    g_init[0] = (a[0] & b[0]) | ((a[0] ^ b[0]) & cin);
  end

  prefix_row #(
    .WIDTH (WIDTH),
    .RW    (RW)
  ) u_row (
    .g     (g_q),
    .p     (p_q),
    .row   (row_cnt),
    .g_nxt (g_row),
    .p_nxt (p_row)
  );

  // Carry into bit i is the final group generate of bits [i-1:0].
  assign carry = {g_row[WIDTH-2:0], cin_q};

  // NOTE: every variable written here gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = PREFIX;
      PREFIX:  if (last_row) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = in_valid ? PREFIX : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_cnt <= '0;
      g_q     <= '0;
      p_q     <= '0;
      h_q     <= '0;
      cin_q   <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else if (accept) begin
      h_q     <= a ^ b;
      g_q     <= g_init;
      p_q     <= a ^ b;
      cin_q   <= cin;
      row_cnt <= '0;
    end else if (state == PREFIX) begin
      g_q <= g_row;
      p_q <= p_row;
      if (last_row) begin
        sum_q   <= h_q ^ carry;
        cout_q  <= g_row[WIDTH-1];
        row_cnt <= '0;
      end else begin
        row_cnt <= row_cnt + RW'(1);
      end
    end
  end

endmodule
